// File: rtl/memory_stage.sv
// Memory pipeline stage: issues loads/stores on a single-outstanding req/ack bus,
// steers byte lanes, extends load data, and flags misaligned or timed-out accesses.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        i_valid,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_store_data,
  input  logic        i_mem_rw,
  input  logic [2:0]  i_load_store_mode,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_reg_wr_en,
  input  logic        i_pc_sel,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_pc_inc,

  output logic        o_stall,

  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata,

  output logic        o_mem_valid,
  output logic [31:0] o_mem_inst,
  output logic [31:0] o_mem_alu_result,
  output logic [31:0] o_mem_load_data,
  output logic [1:0]  o_mem_wb_sel,
  output logic        o_mem_reg_wr_en,
  output logic        o_mem_pc_sel,
  output logic [31:0] o_mem_pc,
  output logic [31:0] o_mem_pc_inc,
  output logic [1:0]  o_mem_fault
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] FAULT_NONE      = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN  = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT   = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        dmem_req_q, dmem_req_d;
  logic        dmem_we_q, dmem_we_d;
  logic [31:0] dmem_addr_q, dmem_addr_d;
  logic [31:0] dmem_wdata_q, dmem_wdata_d;
  logic [3:0]  dmem_be_q, dmem_be_d;
  logic [2:0]  mode_q, mode_d;

  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_inst_q, mem_inst_d;
  logic [31:0] mem_alu_result_q, mem_alu_result_d;
  logic [31:0] mem_load_data_q, mem_load_data_d;
  logic [1:0]  mem_wb_sel_q, mem_wb_sel_d;
  logic        mem_reg_wr_en_q, mem_reg_wr_en_d;
  logic        mem_pc_sel_q, mem_pc_sel_d;
  logic [31:0] mem_pc_q, mem_pc_d;
  logic [31:0] mem_pc_inc_q, mem_pc_inc_d;
  logic [1:0]  mem_fault_q, mem_fault_d;

  logic        is_load, is_store, mem_op;
  logic        size_byte, size_half;
  logic        misaligned;
  logic [1:0]  lane;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_data;

  function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                              input logic [1:0]  ln,
                                              input logic [2:0]  mode);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = ln[1] ? rdata[31:16] : rdata[15:0];
    case (mode)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'b0, b};
      3'b101:  extend_load = {16'b0, h};
      default: extend_load = rdata;
    endcase
  endfunction

  // Undefined size encodings fall into the word case everywhere.
  assign is_load    = i_valid && (i_inst[6:0] == 7'b0000011);
  assign is_store   = i_valid && i_mem_rw;
  assign mem_op     = is_load || is_store;
  assign size_byte  = (i_load_store_mode[1:0] == 2'b00);
  assign size_half  = (i_load_store_mode[1:0] == 2'b01);
  assign lane       = i_alu_result[1:0];
  assign misaligned = (size_half && lane[0]) ||
                      (!size_byte && !size_half && (lane != 2'b00));

  always_comb begin
    st_wdata = i_store_data;
    st_be    = 4'b1111;
    if (size_byte) begin
      st_wdata = {4{i_store_data[7:0]}};
      st_be    = 4'b0001 << lane;
    end else if (size_half) begin
      st_wdata = {2{i_store_data[15:0]}};
      st_be    = 4'b0011 << lane;
    end
  end

  // The latched alu result keeps the byte offset that the bus address drops.
  assign ld_data = extend_load(i_dmem_rdata, mem_alu_result_q[1:0], mode_q);

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wdata_d     = dmem_wdata_q;
    dmem_be_d        = dmem_be_q;
    mode_d           = mode_q;
    mem_valid_d      = mem_valid_q;
    mem_inst_d       = mem_inst_q;
    mem_alu_result_d = mem_alu_result_q;
    mem_load_data_d  = mem_load_data_q;
    mem_wb_sel_d     = mem_wb_sel_q;
    mem_reg_wr_en_d  = mem_reg_wr_en_q;
    mem_pc_sel_d     = mem_pc_sel_q;
    mem_pc_d         = mem_pc_q;
    mem_pc_inc_d     = mem_pc_inc_q;
    mem_fault_d      = mem_fault_q;
    o_stall          = 1'b0;

    case (state_q)
      S_IDLE: begin
        mem_valid_d      = i_valid;
        mem_inst_d       = i_inst;
        mem_alu_result_d = i_alu_result;
        mem_load_data_d  = 32'b0;
        mem_wb_sel_d     = i_wb_sel;
        mem_reg_wr_en_d  = i_reg_wr_en;
        mem_pc_sel_d     = i_pc_sel;
        mem_pc_d         = i_pc;
        mem_pc_inc_d     = i_pc_inc;
        mem_fault_d      = FAULT_NONE;
        if (mem_op && misaligned) begin
          mem_fault_d     = FAULT_MISALIGN;
          mem_reg_wr_en_d = 1'b0;
        end else if (mem_op) begin
          o_stall      = 1'b1;
          mem_valid_d  = 1'b0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = is_store;
          dmem_addr_d  = {i_alu_result[31:2], 2'b00};
          dmem_wdata_d = st_wdata;
          dmem_be_d    = st_be;
          mode_d       = i_load_store_mode;
          cnt_d        = '0;
          state_d      = S_WAIT;
        end
      end

      S_WAIT: begin
        o_stall = 1'b1;
        if (i_dmem_ack) begin
          o_stall         = 1'b0;
          dmem_req_d      = 1'b0;
          mem_valid_d     = 1'b1;
          mem_fault_d     = FAULT_NONE;
          mem_load_data_d = dmem_we_q ? 32'b0 : ld_data;
          state_d         = S_IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          o_stall         = 1'b0;
          dmem_req_d      = 1'b0;
          mem_valid_d     = 1'b1;
          mem_fault_d     = FAULT_TIMEOUT;
          mem_reg_wr_en_d = 1'b0;
          mem_load_data_d = 32'b0;
          state_d         = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= 32'b0;
      dmem_wdata_q     <= 32'b0;
      dmem_be_q        <= 4'b0;
      mode_q           <= 3'b0;
      mem_valid_q      <= 1'b0;
      mem_inst_q       <= 32'b0;
      mem_alu_result_q <= 32'b0;
      mem_load_data_q  <= 32'b0;
      mem_wb_sel_q     <= 2'b0;
      mem_reg_wr_en_q  <= 1'b0;
      mem_pc_sel_q     <= 1'b0;
      mem_pc_q         <= 32'b0;
      mem_pc_inc_q     <= 32'b0;
      mem_fault_q      <= 2'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wdata_q     <= dmem_wdata_d;
      dmem_be_q        <= dmem_be_d;
      mode_q           <= mode_d;
      mem_valid_q      <= mem_valid_d;
      mem_inst_q       <= mem_inst_d;
      mem_alu_result_q <= mem_alu_result_d;
      mem_load_data_q  <= mem_load_data_d;
      mem_wb_sel_q     <= mem_wb_sel_d;
      mem_reg_wr_en_q  <= mem_reg_wr_en_d;
      mem_pc_sel_q     <= mem_pc_sel_d;
      mem_pc_q         <= mem_pc_d;
      mem_pc_inc_q     <= mem_pc_inc_d;
      mem_fault_q      <= mem_fault_d;
    end
  end

  assign o_dmem_req       = dmem_req_q;
  assign o_dmem_we        = dmem_we_q;
  assign o_dmem_addr      = dmem_addr_q;
  assign o_dmem_wdata     = dmem_wdata_q;
  assign o_dmem_be        = dmem_be_q;
  assign o_mem_valid      = mem_valid_q;
  assign o_mem_inst       = mem_inst_q;
  assign o_mem_alu_result = mem_alu_result_q;
  assign o_mem_load_data  = mem_load_data_q;
  assign o_mem_wb_sel     = mem_wb_sel_q;
  assign o_mem_reg_wr_en  = mem_reg_wr_en_q;
  assign o_mem_pc_sel     = mem_pc_sel_q;
  assign o_mem_pc         = mem_pc_q;
  assign o_mem_pc_inc     = mem_pc_inc_q;
  assign o_mem_fault      = mem_fault_q;

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes the execute pipeline register (instruction, ALU result, load/store mode, wb select, PC values).
- Performs loads and stores over a single-outstanding req/ack data-memory bus, with byte-lane steering and load sign/zero extension.
- Detects misaligned accesses and bus timeouts, stalls upstream while an access is in flight, and registers results for the writeback stage.

Parameters:
TIMEOUT_CYCLES, 16, number of WAIT cycles without i_dmem_ack before the access is aborted with a timeout fault (minimum 1)

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
i_valid  in  1  execute register holds a valid instruction
i_inst  in  32  instruction; opcode = [6:0]
i_alu_result  in  32  effective address, or non-memory ALU result
i_store_data  in  32  rs2 value for stores
i_mem_rw  in  1  1 = store, 0 = no store
i_load_store_mode  in  3  funct3 encoding: 000 byte, 001 half, 010 word, 100 byte unsigned, 101 half unsigned
i_wb_sel  in  2  writeback select, passed through
i_reg_wr_en  in  1  register write enable, passed through
i_pc_sel  in  1  passed through
i_pc  in  32  passed through
i_pc_inc  in  32  passed through
o_stall  out  1  upstream must hold its register this cycle
o_dmem_req  out  1  bus request, registered
o_dmem_we  out  1  1 = write
o_dmem_addr  out  32  word-aligned address ({addr[31:2], 2'b00})
o_dmem_wdata  out  32  lane-steered store data
o_dmem_be  out  4  byte enables
i_dmem_ack  in  1  one-cycle completion pulse
i_dmem_rdata  in  32  read word; valid with ack
o_mem_valid  out  1  writeback register valid
o_mem_inst  out  32  instruction
o_mem_alu_result  out  32  ALU result
o_mem_load_data  out  32  extended load data
o_mem_wb_sel  out  2  writeback select
o_mem_reg_wr_en  out  1  register write enable (forced 0 on fault)
o_mem_pc_sel  out  1  PC select
o_mem_pc  out  32  PC
o_mem_pc_inc  out  32  PC + 4
o_mem_fault  out  2  00 none, 01 misaligned, 10 timeout

Behaviour:
- Reset (synchronous): state=IDLE, timeout counter=0, every output 0 (o_stall is combinational and is 0 while in IDLE with i_valid=0).
- Access classification:
  - load = i_valid && opcode==7'b0000011.
  - store = i_valid && i_mem_rw.
  - mem_op = load || store.
- Misaligned: half access with addr[0]=1, or word access with addr[1:0]!=0.
  - No bus request is issued; the instruction completes in 1 cycle.
  - o_mem_fault=01, o_mem_reg_wr_en=0.
- Non-memory op or bubble: 1-cycle latency.
  - Output register loads the inputs; o_mem_valid=i_valid; o_mem_load_data=0.
- FSM states: IDLE and WAIT.
  - IDLE with an aligned mem_op: o_stall=1 (combinational).
    - At the clock edge: latch addr, we, be, wdata, and all pass-through fields.
    - Set o_dmem_req=1, clear the counter, go to WAIT.
    - Set o_mem_valid=0 for that edge.
  - WAIT, no ack: hold o_dmem_req and all bus fields stable; o_stall=1; counter+1.
  - WAIT with i_dmem_ack: o_stall=0 in the same cycle, so upstream advances on that edge.
    - At the edge: o_dmem_req=0, o_mem_valid=1, o_mem_fault=00.
    - o_mem_load_data = extended rdata for loads, 0 for stores.
    - Go to IDLE.
  - WAIT with counter==TIMEOUT_CYCLES-1 and no ack:
    - Drop o_dmem_req, o_mem_valid=1, o_mem_fault=10, o_mem_reg_wr_en=0, o_stall=0, go to IDLE.
  - Ack and timeout in the same cycle: ack wins.
  - i_dmem_ack while in IDLE: ignored.
- Store steering by lane = addr[1:0]:
  - SB: wdata = byte replicated x4, be = 4'b0001<<lane.
  - SH: wdata = half replicated x2, be = 4'b0011<<lane.
  - SW: wdata = i_store_data, be = 4'b1111.
- Load extraction:
  - Select the byte at lane, or the half at lane[1].
  - Sign-extend for modes 000/001, zero-extend for 100/101; word as-is.
  - Undefined modes (011, 110, 111) are treated as word.
- Reset mid-WAIT: o_dmem_req drops at that edge; a late ack is ignored; no writeback is produced.

Test Plan:
- ADD (opcode 0110011), alu_result=0x00000055, i_valid=1 -> next cycle o_mem_valid=1, o_mem_alu_result=0x55, o_stall=0, no o_dmem_req.
- SB, addr=0x1003, store_data=0x000000AB, ack after 3 WAIT cycles -> o_dmem_addr=0x1000, be=1000, wdata=0xABABABAB; o_stall high 4 cycles; o_mem_valid=1 on the ack edge.
- LB, addr=0x2002, rdata=0x00800000 -> load_data=0xFFFFFF80; same access as LBU -> 0x00000080; LH at 0x2002 with rdata=0x8001_0000 -> 0xFFFF8001.
- LW, addr=0x3001 -> no o_dmem_req, 1-cycle completion, o_mem_fault=01, o_mem_reg_wr_en=0, o_stall never asserted.
- LW, addr=0x4000, TIMEOUT_CYCLES=4, ack never arrives -> req held exactly 4 cycles then drops; o_mem_fault=10, o_mem_reg_wr_en=0; a following ADD completes normally.
- Reset asserted during the second WAIT cycle, ack the following cycle -> o_dmem_req=0 after the reset edge, o_mem_valid stays 0, state IDLE.
